// File: rtl/hazard_sched_ctrl_if.sv
// Issue / writeback / branch bundle between the ID-side pipeline and the
// central hazard scheduler.
interface hazard_sched_ctrl_if;
    logic       issue_valid;
    logic       issue_ready;
    logic       issue_regwr;
    logic [4:0] issue_rd;
    logic       issue_reada;
    logic       issue_readb;
    logic [4:0] issue_ra;
    logic [4:0] issue_rb;
    logic       issue_done;
    logic       wb_we;
    logic [4:0] wb_rw;
    logic       br_taken;
    logic       stall;
    logic       flush;
    logic       halted;
    logic       sb_err;

    modport master (
        output issue_valid, issue_ready, issue_regwr, issue_rd,
        output issue_reada, issue_readb, issue_ra, issue_rb,
        output issue_done, wb_we, wb_rw, br_taken,
        input  stall, flush, halted, sb_err
    );

    modport slave (
        input  issue_valid, issue_ready, issue_regwr, issue_rd,
        input  issue_reada, issue_readb, issue_ra, issue_rb,
        input  issue_done, wb_we, wb_rw, br_taken,
        output stall, flush, halted, sb_err
    );
endinterface

// File: rtl/hazard_sched_ctrl.sv
// Pipeline scheduler: per-register in-flight write scoreboard, issue stall,
// branch-flush window and halt-drain sequencing. State moves on negedge clk.
module hazard_sched_ctrl #(
    parameter int CNT_W        = 2,
    parameter int FLUSH_CYCLES = 2
) (
    input logic               clk,
    input logic               rst,
    hazard_sched_ctrl_if.slave bus
);
    localparam logic [CNT_W-1:0] PMAX   = '1;
    localparam logic [3:0]       FC     = 4'(FLUSH_CYCLES);
    localparam logic [0:0]       F_IDLE = 1'b0;
    localparam logic [0:0]       F_FLSH = 1'b1;
    localparam logic [1:0]       H_RUN  = 2'd0;
    localparam logic [1:0]       H_DRN  = 2'd1;
    localparam logic [1:0]       H_HLT  = 2'd2;

    logic [CNT_W-1:0] r_pend [32];
    logic [CNT_W-1:0] w_pend_nxt [32];
    logic             r_err;
    logic             w_err;
    logic             w_any;
    logic [0:0]       r_fst;
    logic [3:0]       r_fcnt;
    logic [1:0]       r_hst;
    logic             w_fire;
    logic             w_raw;
    logic             w_waw;
    logic             w_stall;

    assign w_raw = (bus.issue_reada && bus.issue_ra != 5'd0 &&
                    r_pend[bus.issue_ra] != '0) ||
                   (bus.issue_readb && bus.issue_rb != 5'd0 &&
                    r_pend[bus.issue_rb] != '0);
    assign w_waw = bus.issue_regwr && bus.issue_rd != 5'd0 &&
                   r_pend[bus.issue_rd] == PMAX;
    assign w_stall = w_raw || w_waw || (r_hst != H_RUN);
    assign w_fire  = bus.issue_valid && bus.issue_ready &&
                     !w_stall && (r_fst == F_IDLE);

    assign bus.stall  = w_stall;
    assign bus.flush  = (r_fst == F_FLSH);
    assign bus.halted = (r_hst == H_HLT);
    assign bus.sb_err = r_err;

    // Issue and retire of the same register cancel; retire at 0 is an error.
    always_comb begin
        w_err = 1'b0;
        w_any = 1'b0;
        for (int i = 0; i < 32; i++) begin
            w_pend_nxt[i] = r_pend[i];
            if (i == 0) begin
                w_pend_nxt[i] = '0;
            end else begin
                if (w_fire && bus.issue_regwr && bus.issue_rd == 5'(i)) begin
                    if (!(bus.wb_we && bus.wb_rw == 5'(i)))
                        w_pend_nxt[i] = r_pend[i] + 1'b1;
                end else if (bus.wb_we && bus.wb_rw == 5'(i)) begin
                    if (r_pend[i] == '0)
                        w_err = 1'b1;
                    else
                        w_pend_nxt[i] = r_pend[i] - 1'b1;
                end
            end
            if (r_pend[i] != '0)
                w_any = 1'b1;
        end
    end

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++)
                r_pend[i] <= '0;
            r_err <= 1'b0;
        end else begin
            for (int i = 0; i < 32; i++)
                r_pend[i] <= w_pend_nxt[i];
            r_err <= r_err | w_err;
        end
    end

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            r_fst  <= F_IDLE;
            r_fcnt <= 4'd0;
        end else begin
            case (r_fst)
                F_IDLE: begin
                    if (bus.br_taken) begin
                        r_fst  <= F_FLSH;
                        r_fcnt <= FC;
                    end
                end
                default: begin
                    if (bus.br_taken) begin
                        r_fcnt <= FC;
                    end else if (r_fcnt <= 4'd1) begin
                        r_fst  <= F_IDLE;
                        r_fcnt <= 4'd0;
                    end else begin
                        r_fcnt <= r_fcnt - 4'd1;
                    end
                end
            endcase
        end
    end

    // A taken branch during drain means the marker was on a wrong path.
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            r_hst <= H_RUN;
        end else begin
            case (r_hst)
                H_RUN: begin
                    if (w_fire && bus.issue_done)
                        r_hst <= H_DRN;
                end
                H_DRN: begin
                    if (bus.br_taken)
                        r_hst <= H_RUN;
                    else if (!w_any && !bus.wb_we)
                        r_hst <= H_HLT;
                end
                H_HLT:   r_hst <= H_HLT;
                default: r_hst <= H_RUN;
            endcase
        end
    end
endmodule

// File: tb/tb_hazard_sched_ctrl.sv
// Directed-vector bench for hazard_sched_ctrl (CNT_W=2, FLUSH_CYCLES=2).
// Inputs change and outputs are checked just after each negedge.
module tb_hazard_sched_ctrl;
    logic clk;
    logic rst;
    int   n_chk;
    int   n_fail;

    hazard_sched_ctrl_if ifc ();

    hazard_sched_ctrl #(.CNT_W(2), .FLUSH_CYCLES(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clr();
        ifc.issue_valid = 1'b0;
        ifc.issue_ready = 1'b0;
        ifc.issue_regwr = 1'b0;
        ifc.issue_rd    = 5'd0;
        ifc.issue_reada = 1'b0;
        ifc.issue_readb = 1'b0;
        ifc.issue_ra    = 5'd0;
        ifc.issue_rb    = 5'd0;
        ifc.issue_done  = 1'b0;
        ifc.wb_we       = 1'b0;
        ifc.wb_rw       = 5'd0;
        ifc.br_taken    = 1'b0;
    endtask

    task automatic wr(input logic [4:0] rd);
        ifc.issue_valid = 1'b1;
        ifc.issue_ready = 1'b1;
        ifc.issue_regwr = 1'b1;
        ifc.issue_rd    = rd;
    endtask

    task automatic rda(input logic [4:0] ra);
        ifc.issue_valid = 1'b1;
        ifc.issue_ready = 1'b1;
        ifc.issue_reada = 1'b1;
        ifc.issue_ra    = ra;
    endtask

    task automatic ret(input logic [4:0] rw);
        ifc.wb_we = 1'b1;
        ifc.wb_rw = rw;
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst    = 1'b1;
        clr();
        #1;
        chk("rst_stall", ifc.stall, 1'b0);
        chk("rst_flush", ifc.flush, 1'b0);
        chk("rst_halted", ifc.halted, 1'b0);
        chk("rst_sberr", ifc.sb_err, 1'b0);
        tick();
        tick();
        rst = 1'b0;

        // RAW on x5
        tick(); clr(); wr(5'd5); #1;
        chk("raw_prod", ifc.stall, 1'b0);
        tick(); clr(); rda(5'd5); ifc.issue_regwr = 1'b1; ifc.issue_rd = 5'd6; #1;
        chk("raw_stall", ifc.stall, 1'b1);
        tick(); #1;
        chk("raw_hold", ifc.stall, 1'b1);
        ret(5'd5); #1;
        chk("raw_same_ret", ifc.stall, 1'b1);
        tick(); ifc.wb_we = 1'b0; #1;
        chk("raw_release", ifc.stall, 1'b0);
        tick(); clr(); ifc.issue_valid = 1'b1; ifc.issue_readb = 1'b1;
        ifc.issue_rb = 5'd6; #1;
        chk("raw_cons_issued", ifc.stall, 1'b1);
        clr(); ret(5'd6);
        tick(); clr();

        // x0 never hazards
        wr(5'd0);
        tick(); clr(); rda(5'd0); ifc.issue_readb = 1'b1; #1;
        chk("x0_nostall", ifc.stall, 1'b0);
        tick(); clr();

        // WAW saturation on x7
        for (int k = 0; k < 3; k++) begin
            wr(5'd7); #1;
            chk("waw_fill", ifc.stall, 1'b0);
            tick();
        end
        #1;
        chk("waw_sat", ifc.stall, 1'b1);
        ret(5'd7); #1;
        chk("waw_same_ret", ifc.stall, 1'b1);
        tick(); ifc.wb_we = 1'b0; #1;
        chk("waw_release", ifc.stall, 1'b0);
        tick(); #1;
        chk("waw_resat", ifc.stall, 1'b1);
        clr();
        for (int k = 0; k < 3; k++) begin
            ret(5'd7);
            tick();
        end
        clr(); rda(5'd7); #1;
        chk("waw_empty", ifc.stall, 1'b0);
        chk("waw_no_err", ifc.sb_err, 1'b0);
        clr();

        // same-cycle issue/retire on x9, retire of idle x12
        wr(5'd9);
        tick(); ret(5'd9);
        tick(); clr(); rda(5'd9); #1;
        chk("sim_pend_kept", ifc.stall, 1'b1);
        clr(); ret(5'd9);
        tick(); clr(); rda(5'd9); #1;
        chk("sim_pend_zero", ifc.stall, 1'b0);
        chk("sim_err_pre", ifc.sb_err, 1'b0);
        clr(); ret(5'd12);
        tick(); clr(); #1;
        chk("sberr_set", ifc.sb_err, 1'b1);
        tick(); tick();
        chk("sberr_sticky", ifc.sb_err, 1'b1);

        // flush window, issue held off during it
        ifc.br_taken = 1'b1; #1;
        chk("fl_pre", ifc.flush, 1'b0);
        tick(); ifc.br_taken = 1'b0; wr(5'd10); #1;
        chk("fl_c1", ifc.flush, 1'b1);
        tick();
        chk("fl_c2", ifc.flush, 1'b1);
        clr();
        tick();
        chk("fl_end", ifc.flush, 1'b0);
        rda(5'd10); #1;
        chk("fl_no_issue", ifc.stall, 1'b0);
        clr();

        // flush extended by a second branch
        ifc.br_taken = 1'b1;
        tick(); #1;
        chk("flx_c1", ifc.flush, 1'b1);
        tick(); ifc.br_taken = 1'b0; #1;
        chk("flx_c2", ifc.flush, 1'b1);
        tick();
        chk("flx_c3", ifc.flush, 1'b1);
        tick();
        chk("flx_end", ifc.flush, 1'b0);

        // speculative marker: branch during drain returns to run
        wr(5'd4);
        tick(); clr(); ifc.issue_valid = 1'b1; ifc.issue_ready = 1'b1;
        ifc.issue_done = 1'b1; #1;
        chk("spec_done_ok", ifc.stall, 1'b0);
        tick(); clr(); #1;
        chk("spec_drain", ifc.stall, 1'b1);
        ifc.br_taken = 1'b1;
        tick(); clr(); rda(5'd1); #1;
        chk("spec_run", ifc.stall, 1'b0);
        chk("spec_not_halt", ifc.halted, 1'b0);
        clr(); rda(5'd4); #1;
        chk("spec_pend4", ifc.stall, 1'b1);
        tick(); tick();
        rst = 1'b1; #1;
        chk("rstmid_pend", ifc.stall, 1'b0);
        chk("rstmid_err", ifc.sb_err, 1'b0);
        tick(); rst = 1'b0; clr();

        // halt drain
        wr(5'd3);
        tick(); clr(); ifc.issue_valid = 1'b1; ifc.issue_ready = 1'b1;
        ifc.issue_done = 1'b1;
        tick(); clr(); #1;
        chk("hlt_drain_stall", ifc.stall, 1'b1);
        tick();
        chk("hlt_drain", ifc.halted, 1'b0);
        ret(5'd3);
        tick(); clr(); #1;
        chk("hlt_ret_edge", ifc.halted, 1'b0);
        tick();
        chk("hlt_halted", ifc.halted, 1'b1);
        chk("hlt_stall", ifc.stall, 1'b1);
        tick();
        chk("hlt_absorb", ifc.halted, 1'b1);
        #2;
        rst = 1'b1; #1;
        chk("hlt_rst_async", ifc.halted, 1'b0);
        chk("hlt_rst_stall", ifc.stall, 1'b0);
        tick();
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/hazard_sched_ctrl.md
Name: hazard_sched_ctrl

Overview:
- Central pipeline scheduler for the 5-stage RISC-V core; sits beside the ID stage and replaces the per-register protect/conflict logic inside the register file.
- Keeps a per-register scoreboard of in-flight writes and gates ID->EX issue with a stall.
- Sequences the branch-flush window and the halt drain triggered by the 0xdead10cc marker.

Parameters:
- CNT_W, 2, width of each per-register pending-write counter (maximum in-flight writes per register = 2^CNT_W-1).
- FLUSH_CYCLES, 2, number of consecutive cycles flush is held after a taken branch (1..15).

Ports:
- clk  in  1  core clock; all state updates on negedge clk, matching the pipeline registers.
- rst  in  1  asynchronous, active-high reset.
- issue_valid  in  1  ID holds a valid instruction (ID reg_valid, before stall gating).
- issue_ready  in  1  EX in_ready.
- issue_regwr  in  1  ID instruction writes rd.
- issue_rd  in  5  ID destination register.
- issue_reada  in  1  ID instruction reads rs1.
- issue_readb  in  1  ID instruction reads rs2.
- issue_ra  in  5  rs1 index.
- issue_rb  in  5  rs2 index.
- issue_done  in  1  ID instruction is 0xdead10cc.
- wb_we  in  1  WB register write this cycle.
- wb_rw  in  5  WB destination.
- br_taken  in  1  EX resolved a taken branch/jump this cycle.
- stall  out  1  block to ID; ID out_valid must be gated by it.
- flush  out  1  kill IF/ID contents.
- halted  out  1  program finished and pipeline drained.
- sb_err  out  1  sticky: a retire arrived for a register with count 0.

Behaviour:
- Reset (async, any time, including mid-flush or mid-drain):
  - all counters 0; flush FSM IDLE; halt FSM RUN.
  - stall=0, flush=0, halted=0, sb_err=0.
- issue_fire = issue_valid & issue_ready & ~stall & ~flush.
- Scoreboard:
  - pend[0] is hard-wired 0.
  - issue_fire & issue_regwr & rd!=0 increments pend[rd].
  - wb_we & rw!=0 decrements pend[rw].
  - Increment and decrement of the same register in one cycle: net unchanged.
  - Decrement at 0: counter stays 0 and sb_err is set (sticky until rst).
- stall, combinational from registered state and current inputs, is 1 when any of:
  - RAW hazard: (issue_reada & pend[ra]!=0) or (issue_readb & pend[rb]!=0); index 0 never hazards.
  - WAW saturation: issue_regwr & rd!=0 & pend[rd] at maximum (2^CNT_W-1).
  - Halt FSM in DRAIN or HALTED.
- A same-cycle WB retire does not clear the stall; the instruction issues at the earliest one cycle later.
- stall depends only on issue_* fields, not on issue_ready, so ID need not wait for EX readiness.
- Flush FSM:
  - IDLE: br_taken -> FLUSH, load counter with FLUSH_CYCLES.
  - FLUSH: flush=1 (registered output), counter decrements each cycle; -> IDLE when the counter reaches 1 and br_taken=0.
  - br_taken while in FLUSH reloads the counter.
  - flush is asserted in exactly FLUSH_CYCLES consecutive cycles, starting the edge after br_taken.
  - The scoreboard is not modified by a flush: killed instructions are never issued, so they never incremented it.
- Halt FSM:
  - RUN: issue_fire & issue_done -> DRAIN.
  - DRAIN: if all pend == 0 and no WB write pending this cycle -> HALTED. br_taken (the marker was speculative) -> RUN, with priority over the HALTED transition.
  - HALTED: halted=1; stall=1; absorbing until rst.
- Latency:
  - br_taken to flush: 1 edge.
  - Last retire to halted: 1 edge.
  - Counter update: visible on the stall output the cycle after the event.

Test Plan:
- RAW: issue addi x5 (regwr, rd=5), next instr reads ra=5 -> stall=1 until the WB edge with wb_rw=5, pend[5] 1->0, then stall=0 one cycle later and the consumer issues.
- x0: issue regwr rd=0 then read ra=0 -> pend stays 0, stall never asserted.
- WAW saturation (CNT_W=2): three issues to x7 with no retire -> pend[7]=3; fourth write to x7 -> stall=1; one retire of x7 -> issues next cycle.
- Simultaneous events: issue rd=9 and retire rw=9 in the same cycle with pend[9]=1 -> pend[9] stays 1. Retire rw=12 with pend[12]=0 -> sb_err=1 and stays 1.
- Flush (FLUSH_CYCLES=2): br_taken pulse -> flush high for exactly 2 cycles, no issue_fire in between. Second br_taken during the first flush cycle -> flush extends to 2 cycles after that pulse.
- Halt, including reset mid-operation:
  - done issued with pend[3]=1 -> DRAIN, stall=1; after x3 retires -> halted=1 next edge.
  - br_taken during DRAIN -> RUN, halted stays 0.
  - rst asserted in HALTED -> halted=0 and all counters 0 immediately, without waiting for a clock edge.
